// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: ready/valid FIFO feeding a start/data/parity/stop framer.
// Define UART_TX_BREAK_EN to add the tx_break input and the line-break generator.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          baud_tick,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
`ifdef UART_TX_BREAK_EN
  input  logic                          tx_break,
`endif
  output logic                          tx_line,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] S_BREAK  = 3'd6;
`endif

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        count, count_n;
  logic                 push, pop, empty;

  logic [2:0]           state, state_n;
  logic                 tx_n, launch;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;
  logic                 par_en_q, par_bit_q, stop2_q;

  assign empty      = (count == '0);
  assign s_ready    = (count != FULL_LVL);
  assign push       = s_valid && s_ready;
  assign fifo_level = count;
  assign count_n    = count + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_n;
    end
  end

  // Every frame start (from IDLE or at end of frame) funnels through `launch`,
  // so break requests and back-to-back pops are decided in one place.
  always_comb begin
    state_n = state;
    tx_n    = tx_line;
    pop     = 1'b0;
    launch  = 1'b0;
    if (baud_tick) begin
      case (state)
        S_IDLE:  launch = 1'b1;
        S_START: begin
          tx_n    = shift[0];
          state_n = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt == LAST_BIT) begin
            tx_n    = par_en_q ? par_bit_q : 1'b1;
            state_n = par_en_q ? S_PARITY : S_STOP1;
          end else begin
            tx_n = shift[0];
          end
        end
        S_PARITY: begin
          tx_n    = 1'b1;
          state_n = S_STOP1;
        end
        S_STOP1: begin
          if (stop2_q) begin
            tx_n    = 1'b1;
            state_n = S_STOP2;
          end else begin
            launch = 1'b1;
          end
        end
        S_STOP2: launch = 1'b1;
`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          if (!tx_break) begin
            tx_n    = 1'b1;
            state_n = S_IDLE;
          end
        end
`endif
        default: begin
          tx_n    = 1'b1;
          state_n = S_IDLE;
        end
      endcase
      if (launch) begin
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          tx_n    = 1'b0;
          state_n = S_BREAK;
        end else
`endif
        if (!empty) begin
          pop     = 1'b1;
          tx_n    = 1'b0;
          state_n = S_START;
        end else begin
          tx_n    = 1'b1;
          state_n = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx_line   <= 1'b1;
      tx_busy   <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state   <= state_n;
      tx_line <= tx_n;
      tx_busy <= (state_n != S_IDLE) || (count_n != '0);
      if (pop) begin
        shift     <= mem[rd_ptr];
        bit_cnt   <= '0;
        par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_q <= (^mem[rd_ptr]) ^ (parity_mode == 2'b10);
        stop2_q   <= stop2;
      end else if (baud_tick && (state == S_START || state == S_DATA)) begin
        shift <= shift >> 1;
        if (state == S_DATA) bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit/4-deep instance and a 7-bit instance.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;

  logic       a_valid = 1'b0, a_ready, a_stop2 = 1'b0, a_tx, a_busy;
  logic [7:0] a_data = '0;
  logic [1:0] a_pm = 2'b00;
  logic [2:0] a_level;
`ifdef UART_TX_BREAK_EN
  logic       a_brk = 1'b0;
`endif

  logic       b_valid = 1'b0, b_ready, b_stop2 = 1'b0, b_tx, b_busy;
  logic [6:0] b_data = '0;
  logic [1:0] b_pm = 2'b00;
  logic [2:0] b_level;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .parity_mode(a_pm), .stop2(a_stop2),
`ifdef UART_TX_BREAK_EN
    .tx_break(a_brk),
`endif
    .tx_line(a_tx), .tx_busy(a_busy), .fifo_level(a_level)
  );

  uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick),
    .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .parity_mode(b_pm), .stop2(b_stop2),
    .tx_line(b_tx), .tx_busy(b_busy), .fifo_level(b_level)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One baud tick; returns at the falling edge after the ticked rising edge.
  task automatic tick();
    @(negedge clk) baud_tick = 1'b1;
    @(negedge clk) baud_tick = 1'b0;
  endtask

  // Captures n bit periods; first bit ends up most significant.
  task automatic run(input int n, input bit sel_b, output logic [63:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      bits = {bits[62:0], (sel_b ? b_tx : a_tx)};
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk) begin a_valid = 1'b1; a_data = d; end
    @(negedge clk) a_valid = 1'b0;
  endtask

  logic [63:0] bits, bits2;
  logic [7:0]  words [5] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'h77};
  logic [9:0]  fexp  [4] = '{10'b0100000001, 10'b0000000011,
                             10'b0111111111, 10'b0001111001};

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ready", a_ready, 1'b1);
    check("rst_level", a_level, 3'd0);
    rst_n = 1'b1;

    // even parity, one stop bit
    a_pm = 2'b01; a_stop2 = 1'b0;
    push_a(8'hA5);
    check("lat_level", a_level, 3'd1);
    check("lat_busy", a_busy, 1'b1);
    check("lat_tx_idle", a_tx, 1'b1);
    run(11, 1'b0, bits);
    check("even_frame", bits, 64'(11'b01010010101));
    check("even_busy_last", a_busy, 1'b1);
    tick();
    check("even_busy_end", a_busy, 1'b0);
    check("even_tx_end", a_tx, 1'b1);

    // odd parity, two stops; inputs changed mid-frame must be ignored
    a_pm = 2'b10; a_stop2 = 1'b1;
    push_a(8'hA5);
    tick();
    check("odd_start", a_tx, 1'b0);
    a_pm = 2'b00; a_stop2 = 1'b0;
    run(11, 1'b0, bits);
    check("odd_frame", bits, 64'(11'b10100101111));
    check("odd_busy_last", a_busy, 1'b1);
    tick();
    check("odd_busy_end", a_busy, 1'b0);

    // 7-bit, no parity
    b_pm = 2'b00; b_stop2 = 1'b0;
    @(negedge clk) begin b_valid = 1'b1; b_data = 7'h55; end
    @(negedge clk) b_valid = 1'b0;
    run(9, 1'b1, bits);
    check("b7_frame", bits, 64'(9'b010101011));
    check("b7_busy_last", b_busy, 1'b1);
    tick();
    check("b7_busy_end", b_busy, 1'b0);

    // fill with no ticks, then drain back-to-back
    a_pm = 2'b00; a_stop2 = 1'b0;
    @(negedge clk) a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = words[i];
      @(negedge clk);
    end
    check("fill_ready", a_ready, 1'b0);
    check("fill_level", a_level, 3'd4);
    @(negedge clk);
    check("fill_hold_level", a_level, 3'd4);
    a_valid = 1'b0;
    for (int f = 0; f < 4; f++) begin
      run(10, 1'b0, bits);
      check($sformatf("drain_frame%0d", f), bits, 64'(fexp[f]));
      if (f == 0) check("drain_level", a_level, 3'd3);
      check($sformatf("drain_busy%0d", f), a_busy, 1'b1);
    end
    tick();
    check("drain_busy_end", a_busy, 1'b0);
    check("drain_level_end", a_level, 3'd0);
    check("drain_tx_end", a_tx, 1'b1);

    // simultaneous push and pop, then reset mid-DATA
    push_a(8'h00);
    push_a(8'h55);
    check("pp_level_pre", a_level, 3'd2);
    @(negedge clk) begin a_valid = 1'b1; a_data = 8'hAA; baud_tick = 1'b1; end
    @(negedge clk) begin a_valid = 1'b0; baud_tick = 1'b0; end
    check("pp_level", a_level, 3'd2);
    check("pp_start", a_tx, 1'b0);
    tick();
    tick();
    check("mid_data_tx", a_tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx", a_tx, 1'b1);
    check("arst_level", a_level, 3'd0);
    check("arst_busy", a_busy, 1'b0);
    check("arst_ready", a_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    push_a(8'h5A);
    run(10, 1'b0, bits);
    check("post_rst_frame", bits, 64'(10'b0010110101));
    tick();
    check("post_rst_busy", a_busy, 1'b0);

`ifdef UART_TX_BREAK_EN
    push_a(8'hA5);
    push_a(8'h3C);
    run(3, 1'b0, bits);
    a_brk = 1'b1;
    run(7, 1'b0, bits2);
    check("brk_frame_done", {bits[2:0], bits2[6:0]}, 64'(10'b0101001011));
    run(20, 1'b0, bits);
    check("brk_low", bits, 64'd0);
    check("brk_busy", a_busy, 1'b1);
    check("brk_level", a_level, 3'd1);
    a_brk = 1'b0;
    tick();
    check("brk_mark", a_tx, 1'b1);
    run(10, 1'b0, bits);
    check("brk_next_frame", bits, 64'(10'b0001111001));
    tick();
    check("brk_busy_end", a_busy, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, parametrised UART transmitter. It sits between a ready/valid byte producer and the serial pin, driven by the shared single-cycle `baud_tick` strobe. It extends the basic transmitter with four additions:
- configurable data width
- runtime-selectable parity and stop-bit count
- a transmit FIFO with back-to-back framing
- an optional break generator

## Interface
Parameters:
- `DATA_BITS`, 8, payload bits per frame. Legal range 5..9.
- `FIFO_DEPTH`, 4, transmit FIFO entries. Power of two, ≥2.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `baud_tick` in 1: one-`clk`-cycle pulse, once per bit period.
- `s_valid` in 1: producer has a word on `s_data`.
- `s_ready` out 1: FIFO can accept a word.
- `s_data` in `DATA_BITS`: word to send, LSB transmitted first.
- `parity_mode` in 2: 00 none, 01 even, 10 odd, 11 treated as none.
- `stop2` in 1: 1 selects two stop bits, 0 selects one.
- `tx_line` out 1: serial output, idle high.
- `tx_busy` out 1: high while a frame is in flight or the FIFO is non-empty.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.
- `tx_break` in 1: present only with `UART_TX_BREAK_EN`.

## Operation
- Reset values: `tx_line`=1, `tx_busy`=0, `s_ready`=1, `fifo_level`=0, FSM in IDLE.
- Reset asserted mid-frame: `tx_line` goes to 1 asynchronously and the FIFO is flushed.
- Push: occurs when `s_valid && s_ready`.
  - `s_ready` = !full, decoded from registered occupancy only.
  - A pop in the same cycle does not raise `s_ready` in that cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: `fifo_level` unchanged.
- Pop from an empty FIFO never occurs.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE→START: on `baud_tick` with FIFO non-empty.
  - Pop the head word into the shift register.
  - Latch `parity_mode` and `stop2`. Changes to these inputs mid-frame have no effect.
  - Drive `tx_line`=0.
- START→DATA: next tick, drive bit 0. DATA emits one bit per tick, LSB first, with a bit counter from 0 to `DATA_BITS`-1.
- After the last data bit's tick, the next tick goes to PARITY if the latched mode is even or odd, otherwise to STOP1.
  - Even parity bit = XOR of the data bits.
  - Odd parity bit = XNOR of the data bits.
- STOP1: `tx_line`=1 for one bit period. The next tick goes to STOP2 if `stop2` was latched, else it ends the frame.
- STOP2: `tx_line` held 1 for one more bit period; the next tick ends the frame.
- End-of-frame tick:
  - FIFO non-empty: pop and drive the next START bit on that same tick, giving back-to-back frames with no idle gap.
  - FIFO empty: return to IDLE with `tx_line`=1.
- `tx_busy` is registered. It is 1 from the cycle after the first push until the end-of-frame tick that finds the FIFO empty.

## Timing
- `tx_line` changes only on the `clk` edge at which `baud_tick`=1; each bit lasts exactly one tick interval.
- First-bit latency: the word is visible in the FIFO the cycle after the push; the start bit begins on the first `baud_tick` after that.
- Frame length in bit periods = 1 + `DATA_BITS` + (parity ? 1 : 0) + (`stop2` ? 2 : 1).
- `fifo_level` updates the cycle after a push or pop.
- `baud_tick` pulses in consecutive `clk` cycles are legal; each pulse advances one bit.

## Configuration
- Macro: `UART_TX_BREAK_EN`.
- Defined: the `tx_break` port exists.
  - Break request: when `tx_break`=1 on the tick that would start a frame (from IDLE or at end of frame), no pop occurs and `tx_line` is driven 0.
  - `tx_line` stays 0 while `tx_break`=1; a frame in progress always completes first.
  - Release: on the first tick with `tx_break`=0, drive `tx_line`=1 and enter IDLE. The next frame starts no earlier than the following tick, guaranteeing one mark bit.
  - `tx_busy`=1 during break.
- Undefined: the port is absent and break logic is not compiled in.

## Test plan
- Even parity, one stop bit (`DATA_BITS`=8, 0xA5, mode 01, `stop2`=0) → `tx_line` per tick 0,1,0,1,0,0,1,0,1,0,1; 11 periods; then `tx_busy` falls.
- Odd parity, two stop bits (0xA5, mode 10, `stop2`=1) → parity bit 1, two stop bits, 12 periods.
- No parity, 7-bit (`DATA_BITS`=7, 0x55, mode 00) → 0,1,0,1,0,1,0,1,1; 9 periods.
- FIFO fill and drain (`FIFO_DEPTH`=4):
  - 5 pushes with no ticks → `s_ready`=0 after the 4th, `fifo_level`=4, 5th word held.
  - Then run ticks → 4 contiguous frames with no idle bit between them.
- Reset mid-DATA: deassert `rst_n` → `tx_line`=1 immediately, `fifo_level`=0, `tx_busy`=0; a post-reset push sends a clean frame.
- Break (`UART_TX_BREAK_EN`): assert `tx_break` mid-frame → frame completes, `tx_line`=0 for 20 ticks; after release → 1 mark bit, then the queued word is sent.
